// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer family: FSM state
// encoding, default word width and shift-direction selectors.
package serdes_pkg;

  // FSM state encoding, kept as plain constants so older code can compare
  // against raw bit patterns.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Default word width for the serdes blocks.
  localparam int DEFAULT_WIDTH = 8;

  // Shift-direction selectors for the LSB_FIRST parameter.
  localparam bit DIR_MSB_FIRST = 1'b0;
  localparam bit DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out handshake bundle for the PISO serializer.
// The slave modport is the serializer itself; the master modport is the
// producer/consumer side surrounding it.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport slave (
    input  in_data, in_valid, ser_ready,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport master (
    output in_data, in_valid, ser_ready,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/piso_serializer_bit_counter.sv
// Loadable down-counter with a zero flag. Load takes priority over
// decrement; the counter is never decremented past zero by its users.
module bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Count register: reload on a new word, step down per consumed bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out serializer. Accepts a WIDTH-bit word on a
// valid/ready handshake and emits it one bit per accepted cycle with
// first/last markers. A new word may be taken on the same edge the last
// bit of the previous word leaves, so the stream has no bubble.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = DIR_MSB_FIRST
) (
  input logic             clk,
  input logic             rstn,
  piso_serializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CW-1:0]    cnt;
  logic             cnt_zero;
  logic             shifting;
  logic             out_bit;
  logic             bit_acc;
  logic             in_acc;
  logic             in_ready;

  // Output end of the shift register and the one-step shift toward it.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign out_bit       = shreg[0];
      assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end else begin : g_msb_first
      assign out_bit       = shreg[WIDTH-1];
      assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
    end
  endgenerate

  assign shifting = (state == ST_SHIFT);
  assign bit_acc  = shifting && bus.ser_ready;
  // Ready in IDLE, or on the cycle the last bit is consumed (no bubble).
  assign in_ready = !shifting || (bit_acc && cnt_zero);
  assign in_acc   = bus.in_valid && in_ready;

  bit_counter #(
    .W (CW)
  ) u_bit_counter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (in_acc),
    .load_val (CNT_TOP),
    .dec      (bit_acc && !cnt_zero),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Next-state and shift-register update from the two handshakes.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    if (in_acc) begin
      state_next = ST_SHIFT;
      shreg_next = bus.in_data;
    end else if (bit_acc) begin
      if (cnt_zero) begin
        state_next = ST_IDLE;
        shreg_next = '0;
      end else begin
        shreg_next = shreg_shifted;
      end
    end
  end

  // State and shift register; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      shreg <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ser_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.ser_out   = shifting && out_bit;
  assign bus.ser_first = shifting && (cnt == CNT_TOP);
  assign bus.ser_last  = shifting && cnt_zero;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share
// the same stimulus; each has its own scoreboard of expected bits.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       ser_ready;

  int checks = 0;
  int failures = 0;

  logic [2:0] q_msb[$];  // {bit, first, last}
  logic [2:0] q_lsb[$];

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) bus_m ();
  piso_serializer_if #(.WIDTH(8)) bus_l ();

  assign bus_m.in_data   = in_data;
  assign bus_m.in_valid  = in_valid;
  assign bus_m.ser_ready = ser_ready;
  assign bus_l.in_data   = in_data;
  assign bus_l.in_valid  = in_valid;
  assign bus_l.ser_ready = ser_ready;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_m)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_l)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bit sequence for a word in both directions.
  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      q_msb.push_back({w[7-i], i == 0, i == 7});
      q_lsb.push_back({w[i],   i == 0, i == 7});
    end
  endtask

  // MSB-first monitor: one line per consumed bit.
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus_m.ser_valid === 1'b1 && ser_ready === 1'b1) begin
      logic [2:0] e;
      check("msb_sb_nonempty", 32'(q_msb.size() != 0), 32'd1);
      if (q_msb.size() != 0) begin
        e = q_msb.pop_front();
        $display("msb bit: out=%b first=%b last=%b exp=%b", bus_m.ser_out, bus_m.ser_first, bus_m.ser_last, e);
        check("msb_bit", {29'd0, bus_m.ser_out, bus_m.ser_first, bus_m.ser_last}, {29'd0, e});
        check("msb_in_ready", {31'd0, bus_m.in_ready}, {31'd0, e[0]});
        check("msb_busy", {31'd0, bus_m.busy}, 32'd1);
      end
    end
  end

  // LSB-first monitor: one line per consumed bit.
  always @(negedge clk) begin
    if (rstn === 1'b1 && bus_l.ser_valid === 1'b1 && ser_ready === 1'b1) begin
      logic [2:0] e;
      check("lsb_sb_nonempty", 32'(q_lsb.size() != 0), 32'd1);
      if (q_lsb.size() != 0) begin
        e = q_lsb.pop_front();
        $display("lsb bit: out=%b first=%b last=%b exp=%b", bus_l.ser_out, bus_l.ser_first, bus_l.ser_last, e);
        check("lsb_bit", {29'd0, bus_l.ser_out, bus_l.ser_first, bus_l.ser_last}, {29'd0, e});
        check("lsb_in_ready", {31'd0, bus_l.in_ready}, {31'd0, e[0]});
      end
    end
  end

  // Present a word and wait (bounded) for it to be accepted.
  task automatic send(input logic [7:0] w, input bit keep);
    int n;
    @(posedge clk);
    #1;
    in_data  = w;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus_m.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept_ready", {31'd0, bus_m.in_ready}, 32'd1);
    @(posedge clk);
    push_word(w);
    $display("word accepted: %h", w);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  // Wait (bounded) for the stream to go idle, then confirm all bits seen.
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (bus_m.ser_valid === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", {31'd0, bus_m.ser_valid}, 32'd0);
    check("drain_lsb_idle", {31'd0, bus_l.ser_valid}, 32'd0);
    #1;
    check("drain_msb_sb_empty", 32'(q_msb.size()), 32'd0);
    check("drain_lsb_sb_empty", 32'(q_lsb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a word on offer: nothing may be accepted.
    rstn      = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    ser_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, bus_m.in_ready}, 32'd1);
      check("rst_ser_valid", {31'd0, bus_m.ser_valid}, 32'd0);
      check("rst_ser_out", {31'd0, bus_m.ser_out}, 32'd0);
      check("rst_busy", {31'd0, bus_m.busy}, 32'd0);
      check("rst_first_last", {30'd0, bus_m.ser_first, bus_m.ser_last}, 32'd0);
    end
    @(posedge clk);
    #1;
    rstn     = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_no_word", {31'd0, bus_m.ser_valid}, 32'd0);

    // Single word, both directions.
    send(8'hA5, 1'b0);
    drain();

    // Back-to-back: second word taken on the last bit of the first.
    send(8'h3C, 1'b1);
    in_data = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("b2b_valid", {31'd0, bus_m.ser_valid}, 32'd1);
      check("b2b_in_ready", {31'd0, bus_m.in_ready}, {31'd0, (i == 7 || i == 15)});
      @(posedge clk);
      if (i == 7) begin
        push_word(8'hC3);
        #1;
        in_valid = 1'b0;
      end
    end
    drain();

    // Backpressure at the third bit of 8'hF0.
    send(8'hF0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_msb_bit", {29'd0, bus_m.ser_out, bus_m.ser_first, bus_m.ser_last}, 32'b100);
      check("stall_lsb_bit", {29'd0, bus_l.ser_out, bus_l.ser_first, bus_l.ser_last}, 32'b000);
      check("stall_in_ready", {31'd0, bus_m.in_ready}, 32'd0);
      check("stall_valid", {31'd0, bus_m.ser_valid}, 32'd1);
      @(posedge clk);
    end
    #1;
    ser_ready = 1'b1;
    drain();

    // Reset after four bits of 8'hFF, then a clean word.
    send(8'hFF, 1'b0);
    repeat (4) @(posedge clk);
    check("midrst_bits_left", 32'(q_msb.size()), 32'd4);
    #1;
    rstn = 1'b0;
    q_msb.delete();
    q_lsb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", {31'd0, bus_m.ser_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus_m.in_ready}, 32'd1);
    check("midrst_ser_out", {31'd0, bus_m.ser_out}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("after_rst_in_ready", {31'd0, bus_m.in_ready}, 32'd1);
    check("after_rst_valid", {31'd0, bus_l.ser_valid}, 32'd0);
    send(8'h01, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out serializer; the transmit-side counterpart to the serial-in shift chain. It accepts a WIDTH-bit word over a valid/ready handshake, then emits it one bit per accepted cycle on a serial valid/ready stream, with first/last frame markers. It sits between a word-oriented producer and a bit-serial link or a downstream serial-in shift register.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- LSB_FIRST, 0, 0 = bit WIDTH-1 sent first; 1 = bit 0 sent first.
- clk  input  1  clock; all state updates on posedge clk.
- rstn  input  1  reset; synchronous, active-low; sampled on posedge clk.
- in_data  input  WIDTH  parallel word from producer.
- in_valid  input  1  producer has a word.
- in_ready  output  1  serializer can accept a word this cycle.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  consumer takes the bit this cycle.
- ser_first  output  1  current bit is the first bit of the word.
- ser_last  output  1  current bit is the last bit of the word.
- busy  output  1  a word is loaded and not fully sent.

## Operation
- Transfers: input accepted when in_valid && in_ready at posedge; bit accepted when ser_valid && ser_ready at posedge.
- States: IDLE (no word held), SHIFT (word held, bits remaining).
- IDLE -> SHIFT on input accept: shreg <= in_data, cnt <= WIDTH-1.
- SHIFT, bit accepted, cnt != 0: shreg shifts by one toward the output end (left if LSB_FIRST=0, right otherwise), zero fill; cnt <= cnt-1.
- SHIFT, bit accepted, cnt == 0, no input accept: -> IDLE, shreg <= 0.
- SHIFT, bit accepted, cnt == 0, input accept same cycle: stay SHIFT, reload shreg/cnt from in_data (no bubble).
- SHIFT, bit not accepted: hold everything; ser_out/ser_first/ser_last stable while ser_valid && !ser_ready.
- in_ready = (state == IDLE) || (ser_valid && ser_ready && ser_last); combinational from ser_ready. in_data ignored when not accepted.
- ser_out = shreg[WIDTH-1] (LSB_FIRST=0) or shreg[0] (LSB_FIRST=1) in SHIFT; 0 in IDLE.
- ser_valid = busy = (state == SHIFT).
- ser_first = SHIFT && cnt == WIDTH-1; ser_last = SHIFT && cnt == 0.
- cnt width $clog2(WIDTH); never wraps below 0 (reload or IDLE at 0).

## Timing
- Reset (rstn low at posedge): state IDLE, shreg 0, cnt 0; outputs in_ready 1, ser_out 0, ser_valid 0, ser_first 0, ser_last 0, busy 0. Reset wins over any simultaneous transfer.
- Reset mid-word: word discarded, no further bits emitted, in_ready 1 the cycle after reset deasserts.
- Latency: word accepted at edge N -> first bit valid in the cycle after edge N.
- Throughput: with ser_ready held 1 and in_valid held 1, one word per WIDTH cycles, ser_valid continuously 1.
- Stall: ser_ready low holds current bit indefinitely; in_ready low throughout SHIFT except on the accepted last bit.

## Structure
- Shared package serdes_pkg: state encoding (IDLE=1'b0, SHIFT=1'b1), default WIDTH constant, shift-direction constants MSB_FIRST/LSB_FIRST.
- One sub-module, bit_counter: loadable down-counter (load, load_val, dec, zero flag), reusable by the matching deserializer.
- Top holds FSM, shift register, output decode.

## Test plan
- Reset: assert rstn=0 two cycles with in_valid=1 -> in_ready=1, ser_valid=0, ser_out=0, busy=0; no word accepted.
- MSB-first: WIDTH=8, send 8'hA5, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; ser_first on bit 1, ser_last on bit 8; then ser_valid=0.
- LSB-first: LSB_FIRST=1, send 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 reversed order 1,0,1,0,0,1,0,1 checked bitwise as 8'hA5 LSB first; markers same positions.
- Back-to-back: in_valid held with 8'h3C then 8'hC3, ser_ready=1 -> 16 contiguous valid bits 00111100 11000011, in_ready=1 only on the last-bit cycle.
- Backpressure: during 8'hF0, drop ser_ready for 3 cycles at bit 3 -> ser_out/ser_first/ser_last held, in_ready=0; stream resumes, total sequence 11110000.
- Reset mid-word: rstn=0 after 4 bits of 8'hFF -> next cycle ser_valid=0, in_ready=1; following word 8'h01 sent completely and correctly.
